// File: rtl/alu_mdu_if.sv
// alu_mdu_if: issue/result bundle between the EX stage and alu_mdu
// Signals: start, ALUCtrl, a, b - operation issue (driven by master)
//          busy, done         - multi-cycle handshake (driven by slave)
//          ALU_result, zero   - registered result and its zero flag
//          hi, lo             - HI/LO architectural registers
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALU_result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (
        output start, ALUCtrl, a, b,
        input  busy, done, ALU_result, zero, hi, lo
    );
    modport slave (
        input  start, ALUCtrl, a, b,
        output busy, done, ALU_result, zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative multiply/divide and MIPS HI/LO registers
// Ports: clk   - clock, all state changes on the rising edge
//        rst_n - synchronous active-low reset
//        bus   - alu_mdu_if.slave: start/ALUCtrl/a/b issue, busy/done handshake,
//                ALU_result/zero registered result, hi/lo registers
// Build option ALU_MDU_DIV_EN: compiles in the restoring divider. Without it
// DIV/DIVU finish in one cycle with a zero result and HI/LO left untouched.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             neg;
    logic             op_mul;
    logic             op_div;
    logic             sgn;
    logic             sa;
    logic             sb;
    logic             div0;
    logic             mc;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
    assign op_mul = bus.ALUCtrl[3:1] == 3'b100;
    assign op_div = bus.ALUCtrl[3:1] == 3'b101;
    // Odd codes of the MDU group (MULTU/DIVU) are unsigned.
    assign sgn = !bus.ALUCtrl[0];
    assign sa  = sgn && bus.a[WIDTH-1];
    assign sb  = sgn && bus.b[WIDTH-1];
    assign ma  = sa ? -bus.a : bus.a;
    assign mb  = sb ? -bus.b : bus.b;
`ifdef ALU_MDU_DIV_EN
    logic           is_div;
    logic           neg_r;
    logic           ge;
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] r_sub;
    assign div0 = op_div && bus.b == '0;
    assign mc   = op_mul || (op_div && !div0);
    // Partial remainder is always < divisor, so the shifted value fits WIDTH+1
    // bits and the top bit of the difference is a clean borrow flag.
    assign r_sh  = {acc, q[WIDTH-1]};
    assign r_sub = r_sh - {1'b0, m};
    assign ge    = !r_sub[WIDTH];
`else
    assign div0 = 1'b0;
    assign mc   = op_mul;
`endif
    always_comb begin
        sc_res = bus.a;
        case (bus.ALUCtrl)
            4'b0000: sc_res = bus.a & bus.b;
            4'b0001: sc_res = bus.a | bus.b;
            4'b0010: sc_res = bus.a + bus.b;
            4'b0110: sc_res = bus.a - bus.b;
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b0011: sc_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            4'b1100: sc_res = ~(bus.a | bus.b);
            4'b1101: sc_res = bus.hi;
            4'b1110: sc_res = bus.lo;
            4'b1010, 4'b1011: sc_res = div0 ? '1 : '0;
            default: ;
        endcase
    end
    // One MDU iteration per RUN cycle; fin_* is the architectural result as
    // it would look if this were the last iteration.
    always_comb begin
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        acc_n   = mul_sum[WIDTH:1];
        q_n     = {mul_sum[0], q[WIDTH-1:1]};
        prod    = neg ? -{acc_n, q_n} : {acc_n, q_n};
        fin_hi  = prod[2*WIDTH-1:WIDTH];
        fin_lo  = prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
        if (is_div) begin
            acc_n  = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
            q_n    = {q[WIDTH-2:0], ge};
            fin_hi = neg_r ? -acc_n : acc_n;
            fin_lo = neg ? -q_n : q_n;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            q              <= '0;
            m              <= '0;
            neg            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.ALU_result <= '0;
            bus.zero       <= 1'b0;
            bus.hi         <= '0;
            bus.lo         <= '0;
`ifdef ALU_MDU_DIV_EN
            is_div         <= 1'b0;
            neg_r          <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (state == RUN) begin
                acc <= acc_n;
                q   <= q_n;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    state          <= DONE;
                    bus.busy       <= 1'b0;
                    bus.done       <= 1'b1;
                    bus.hi         <= fin_hi;
                    bus.lo         <= fin_lo;
                    bus.ALU_result <= fin_lo;
                    bus.zero       <= fin_lo == '0;
                end
            end else begin
                // DONE accepts a new issue exactly like IDLE, since busy is low.
                state <= IDLE;
                if (bus.start && mc) begin
                    state    <= RUN;
                    bus.busy <= 1'b1;
                    cnt      <= CW'(WIDTH - 1);
                    acc      <= '0;
                    q        <= op_div ? ma : mb;
                    m        <= op_div ? mb : ma;
                    neg      <= sa ^ sb;
`ifdef ALU_MDU_DIV_EN
                    is_div   <= op_div;
                    neg_r    <= sa;
`endif
                end else if (bus.start) begin
                    state          <= DONE;
                    bus.done       <= 1'b1;
                    bus.ALU_result <= sc_res;
                    bus.zero       <= sc_res == '0;
                    if (div0) begin
                        bus.hi <= bus.a;
                        bus.lo <= '1;
                    end
                end
            end
        end
    end
endmodule
